// File: rtl/pwm_ramp_controller.sv
// PWM ramp sequencer: owns the PWM driver's cycle/duty, applies new targets at period boundaries
// and ramps duty by a fixed step per period. Optional `PWM_RAMP_ABORT_EN adds an abort input.
module pwm_ramp_controller #(
  parameter int unsigned COUNTER_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef PWM_RAMP_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [COUNTER_BITS-1:0] cfg_cycle,
  input  logic [COUNTER_BITS-1:0] cfg_duty,
  input  logic [COUNTER_BITS-1:0] cfg_step,
  output logic [COUNTER_BITS-1:0] cycle,
  output logic [COUNTER_BITS-1:0] duty,
  output logic                    period_tick,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {StIdle, StPending, StRamp} state_e;

  state_e                  state_q;
  logic [COUNTER_BITS-1:0] counter_q;
  logic [COUNTER_BITS-1:0] cycle_q;
  logic [COUNTER_BITS-1:0] duty_q;
  logic [COUNTER_BITS-1:0] tgt_cycle_q;
  logic [COUNTER_BITS-1:0] tgt_duty_q;
  logic [COUNTER_BITS-1:0] tgt_step_q;
  logic                    done_q;

  logic                    abort_req;
  logic                    transfer;
  logic [COUNTER_BITS-1:0] cfg_duty_clamped;
  logic [COUNTER_BITS-1:0] work_duty;
  logic [COUNTER_BITS-1:0] stepped_duty;

`ifdef PWM_RAMP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign period_tick = (cycle_q == '0) | (counter_q >= cycle_q - COUNTER_BITS'(1));
  assign cfg_ready   = (state_q == StIdle) & ~abort_req;
  assign transfer    = cfg_valid & cfg_ready;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign cycle       = cycle_q;
  assign duty        = duty_q;

  assign cfg_duty_clamped = (cfg_duty > cfg_cycle) ? cfg_cycle : cfg_duty;

  // Differences are taken in the safe direction so the step never overflows or overshoots.
  always_comb begin
    work_duty = duty_q;
    if (state_q == StPending && duty_q > tgt_cycle_q) begin
      work_duty = tgt_cycle_q;
    end
    if (work_duty < tgt_duty_q) begin
      stepped_duty = (tgt_duty_q - work_duty <= tgt_step_q) ? tgt_duty_q : work_duty + tgt_step_q;
    end else begin
      stepped_duty = (work_duty - tgt_duty_q <= tgt_step_q) ? tgt_duty_q : work_duty - tgt_step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      counter_q   <= '0;
      cycle_q     <= '0;
      duty_q      <= '0;
      tgt_cycle_q <= '0;
      tgt_duty_q  <= '0;
      tgt_step_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      counter_q <= period_tick ? '0 : counter_q + COUNTER_BITS'(1);
      if (abort_req) begin
        state_q     <= StIdle;
        duty_q      <= '0;
        tgt_cycle_q <= '0;
        tgt_duty_q  <= '0;
        tgt_step_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (transfer) begin
              tgt_cycle_q <= cfg_cycle;
              tgt_duty_q  <= cfg_duty_clamped;
              tgt_step_q  <= cfg_step;
              state_q     <= StPending;
            end
          end
          StPending: begin
            if (period_tick) begin
              cycle_q <= tgt_cycle_q;
              if (tgt_step_q == '0 || work_duty == tgt_duty_q) begin
                duty_q  <= tgt_duty_q;
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                duty_q  <= stepped_duty;
                state_q <= StRamp;
              end
            end
          end
          StRamp: begin
            if (period_tick) begin
              duty_q <= stepped_duty;
              if (stepped_duty == tgt_duty_q) begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Self-checking bench for pwm_ramp_controller: directed and random targets against a
// duty-sequence reference model. Define PWM_RAMP_ABORT_EN to also exercise abort.
module tb_pwm_ramp_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_cycle = '0;
  logic [31:0] cfg_duty = '0;
  logic [31:0] cfg_step = '0;
  logic [31:0] cycle;
  logic [31:0] duty;
  logic        period_tick;
  logic        busy;
  logic        done;
`ifdef PWM_RAMP_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cur_cycle = 0;
  int cur_duty = 0;

  pwm_ramp_controller #(.COUNTER_BITS(32)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PWM_RAMP_ABORT_EN
    .abort      (abort),
`endif
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_cycle  (cfg_cycle),
    .cfg_duty   (cfg_duty),
    .cfg_step   (cfg_step),
    .cycle      (cycle),
    .duty       (duty),
    .period_tick(period_tick),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int step_to(int x, int t, int s);
    if (x < t) return (t - x <= s) ? t : x + s;
    return (x - t <= s) ? t : x - s;
  endfunction

  // Track a transfer already accepted: every tick edge must show the next duty of the ramp.
  task automatic follow(input int c, input int d, input int s);
    int tgt, x, i, since, budget;
    int seq[$];
    bit tk, applied;
    tgt = (d > c) ? c : d;
    x = (cur_duty > c) ? c : cur_duty;
    if (s == 0 || x == tgt) begin
      seq.push_back(tgt);
    end else begin
      x = step_to(x, tgt, s);
      seq.push_back(x);
      do begin
        x = step_to(x, tgt, s);
        seq.push_back(x);
      end while (x != tgt);
    end
    i = 0; since = 0; budget = 0; applied = 0;
    while (i < seq.size() && budget < 3000) begin
      tk = period_tick;
      n_checks++;
      if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ready: got busy=%b ready=%b, required busy=1 ready=0", busy, cfg_ready);
      end
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_cycle = $urandom_range(0, 15);
      cfg_duty  = $urandom_range(0, 15);
      cfg_step  = $urandom_range(0, 3);
      @(posedge clk); @(negedge clk);
      budget++; since++;
      if (tk) begin
        if (applied) begin
          n_checks++;
          if (since != ((c == 0) ? 1 : c)) begin
            n_fail++;
            $display("FAIL tick_interval: got %0d clks, required %0d", since, (c == 0) ? 1 : c);
          end
        end
        n_checks++;
        if (cycle !== 32'(c) || duty !== 32'(seq[i]) || done !== (i == seq.size() - 1)) begin
          n_fail++;
          $display("FAIL ramp_step%0d: got cycle=%0d duty=%0d done=%b, required %0d %0d %b",
                   i, cycle, duty, done, c, seq[i], i == seq.size() - 1);
        end
        applied = 1; since = 0; i++;
      end else begin
        n_checks++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_off_tick: got done=%b, required 0", done);
        end
      end
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (budget >= 3000 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_end: got busy=%b ready=%b budget=%0d, required 0 1 <3000",
               busy, cfg_ready, budget);
    end
    cur_cycle = c;
    cur_duty  = tgt;
  endtask

  // Offer a target from IDLE after a random idle gap, then follow it.
  task automatic send(input int c, input int d, input int s);
    int gap;
    gap = $urandom_range(0, 3);
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (duty !== 32'(cur_duty) || cycle !== 32'(cur_cycle) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold: got cycle=%0d duty=%0d done=%b, required %0d %0d 0",
                 cycle, duty, done, cur_cycle, cur_duty);
      end
    end
    cfg_valid = 1'b1; cfg_cycle = c; cfg_duty = d; cfg_step = s;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_idle: got %b, required 1", cfg_ready);
    end
    @(posedge clk); @(negedge clk);
    cfg_valid = 1'b0;
    follow(c, d, s);
  endtask

  task automatic test_reset;
    reset = 1'b0; cfg_valid = 1'b1; cfg_cycle = 10; cfg_duty = 6; cfg_step = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (cycle !== 0 || duty !== 0 || cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got cycle=%0d duty=%0d ready=%b busy=%b done=%b, required 0 0 1 0 0",
                 cycle, duty, cfg_ready, busy, done);
      end
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_valid = 1'b0;
    cur_cycle = 0; cur_duty = 0;
    follow(10, 6, 0);
  endtask

  task automatic test_period;
    int since, nt;
    since = 0; nt = 0;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); @(negedge clk);
      since++;
      if (period_tick) begin
        nt++;
        if (nt > 1) begin
          n_checks++;
          if (since != cur_cycle) begin
            n_fail++;
            $display("FAIL idle_period: got %0d clks between ticks, required %0d", since, cur_cycle);
          end
        end
        since = 0;
      end
    end
  endtask

  task automatic test_directed;
    send(10, 0, 0);
    send(10, 7, 3);
    send(100, 50, 0);
    send(20, 5, 10);
    send(20, 30, 0);
    send(20, 20, 5);
    send(20, 4, 2);
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      send($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_mid_ramp;
    int budget;
    send(8, 0, 0);
    cfg_valid = 1'b1; cfg_cycle = 8; cfg_duty = 8; cfg_step = 1;
    @(posedge clk); @(negedge clk);
    cfg_valid = 1'b0;
    budget = 0;
    while (duty !== 32'd3 && budget < 200) begin
      @(posedge clk); @(negedge clk);
      budget++;
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (budget >= 200 || cycle !== 0 || duty !== 0 || busy !== 1'b0 || done !== 1'b0 ||
        cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ramp: got cycle=%0d duty=%0d busy=%b done=%b ready=%b, required 0 0 0 0 1",
               cycle, duty, busy, done, cfg_ready);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || duty !== 0) begin
      n_fail++;
      $display("FAIL reset_no_resume: got done=%b busy=%b duty=%0d, required 0 0 0", done, busy, duty);
    end
    cur_cycle = 0; cur_duty = 0;
  endtask

`ifdef PWM_RAMP_ABORT_EN
  task automatic test_abort;
    int budget;
    send(12, 0, 0);
    cfg_valid = 1'b1; cfg_cycle = 12; cfg_duty = 9; cfg_step = 3;
    @(posedge clk); @(negedge clk);
    cfg_valid = 1'b0;
    budget = 0;
    while (duty !== 32'd6 && budget < 200) begin
      @(posedge clk); @(negedge clk);
      budget++;
    end
    abort = 1'b1; cfg_valid = 1'b1; cfg_cycle = 5; cfg_duty = 3; cfg_step = 0;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: got %b, required 0", cfg_ready);
    end
    @(posedge clk); @(negedge clk);
    abort = 1'b0; cfg_valid = 1'b0;
    n_checks++;
    if (budget >= 200 || duty !== 0 || cycle !== 32'd12 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got duty=%0d cycle=%0d busy=%b done=%b, required 0 12 0 0",
               duty, cycle, busy, done);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_transfer: got busy=%b done=%b, required 0 0", busy, done);
    end
    cur_cycle = 12; cur_duty = 0;
    send(12, 5, 2);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_period;
    test_directed;
    test_random;
    test_reset_mid_ramp;
`ifdef PWM_RAMP_ABORT_EN
    test_abort;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
